// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event decoder slice.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } key_state_t;

  localparam int KEY_CNT_W = 16;

  localparam int unsigned DEF_TICK_DIV     = 10_000;
  localparam int unsigned DEF_LONG_TICKS   = 800;
  localparam int unsigned DEF_REPEAT_TICKS = 200;

endpackage

// File: rtl/key_event_fsm.sv
// Per-key classifier: short press, long press and (with KEY_REPEAT_EN) auto-repeat pulses.
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic [KEY_CNT_W-1:0] LONG_LAST = KEY_CNT_W'(LONG_TICKS - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [KEY_CNT_W-1:0] REPEAT_LAST = KEY_CNT_W'(REPEAT_TICKS - 1);
`endif

  if (LONG_TICKS < 1 || LONG_TICKS > 65535) begin : g_bad_long
    $error("key_event_fsm: LONG_TICKS out of range");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS > 65535) begin : g_bad_repeat
    $error("key_event_fsm: REPEAT_TICKS out of range");
  end

  key_state_t            state_r;
  logic                  prev_r;
  logic [KEY_CNT_W-1:0]  cnt_r;
  logic                  rise_s;
  logic                  fall_s;

  assign rise_s = key_level & ~prev_r;
  assign fall_s = ~key_level & prev_r;

  // Classifier state machine; a release always beats a threshold tick in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      prev_r       <= 1'b0;
      cnt_r        <= 16'd0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      prev_r       <= key_level;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r <= PRESSED;
            cnt_r   <= 16'd0;
          end
        end
        PRESSED: begin
          if (fall_s) begin
            short_pulse <= 1'b1;
            state_r     <= IDLE;
          end else if (tick) begin
            if (cnt_r == LONG_LAST) begin
              long_pulse <= 1'b1;
              cnt_r      <= 16'd0;
              state_r    <= LONG_HELD;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
        end
        LONG_HELD: begin
          if (fall_s) begin
            state_r <= IDLE;
          end
`ifdef KEY_REPEAT_EN
          else if (tick) begin
            if (cnt_r == REPEAT_LAST) begin
              repeat_pulse <= 1'b1;
              cnt_r        <= 16'd0;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
`endif
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Shared tick prescaler plus one key_event_fsm per key. Optional auto-repeat: define KEY_REPEAT_EN.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_pressed,
  output logic [WIDTH-1:0] short_pulse,
  output logic [WIDTH-1:0] long_pulse,
  output logic [WIDTH-1:0] repeat_pulse
);

  localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("key_event_decoder: TICK_DIV must be at least 2");
  end

  logic [PRESC_W-1:0] presc_r;
  logic               tick_s;

  assign tick_s = (presc_r == PRESC_LAST);

  // Free-running prescaler; its phase is independent of key activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {PRESC_W{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PRESC_W{1'b0}};
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_event_fsm #(
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick_s),
      .key_level    (key_pressed[i]),
      .short_pulse  (short_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Consumes the debounced, active-high key levels from the button debounce stage and classifies each key's activity into short-press, long-press and auto-repeat single-cycle pulses for the countdown control FSM. One independent classifier runs per key. All classifiers share a millisecond tick prescaler. The block sits between the debouncer and the countdown controller, in the same `clk` domain.

## Interface
- `WIDTH`, 4: number of keys.
- `TICK_DIV`, 10_000: `clk` cycles per time tick (1 ms at 10 MHz); must be ≥ 2.
- `LONG_TICKS`, 800: ticks held in PRESSED before a long press is declared; range 1..65535.
- `REPEAT_TICKS`, 200: ticks between auto-repeat pulses in LONG_HELD; range 1..65535.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `key_pressed` in WIDTH: debounced key level; 1 = held; already synchronous to `clk`.
- `short_pulse` out WIDTH: one-cycle pulse when a key is released before the long threshold.
- `long_pulse` out WIDTH: one-cycle pulse when the long threshold is reached while the key is still held.
- `repeat_pulse` out WIDTH: one-cycle pulse every `REPEAT_TICKS` while the key stays held after a long press.

## Operation
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - Internal `tick` is high in the cycle the count equals TICK_DIV-1.
  - Free-running; the count is not cleared on key press.
- Per key `i`:
  - Registered `prev[i]` tracks the key level.
  - `rise = key_pressed[i] & ~prev[i]` and `fall = ~key_pressed[i] & prev[i]`.
  - 16-bit tick counter `cnt[i]`.
- FSM states: IDLE, PRESSED, LONG_HELD.
  - IDLE → PRESSED on `rise`; `cnt` ← 0.
  - PRESSED:
    - On `fall`: `short_pulse[i]` ← 1, go to IDLE.
    - Otherwise, on `tick`: if `cnt == LONG_TICKS-1`, then `long_pulse[i]` ← 1, `cnt` ← 0, go to LONG_HELD. Else `cnt` ← `cnt+1`.
  - LONG_HELD:
    - On `fall`: go to IDLE. No pulse.
    - Otherwise, on `tick`: if `cnt == REPEAT_TICKS-1`, then `repeat_pulse[i]` ← 1 and `cnt` ← 0. Else `cnt` ← `cnt+1`.
- Simultaneous `fall` and threshold tick in the same cycle: `fall` wins. PRESSED gives `short_pulse` only; LONG_HELD gives no repeat.
- At most one of the three outputs is high per key per cycle. Keys are fully independent, so pulses on different bits may coincide.
- A key held through reset deassertion counts as a new press, because `prev` resets to 0.

## Timing
- All outputs are registered and default to 0 every cycle, so each pulse lasts exactly one cycle.
- Reset values: all outputs 0; every FSM in IDLE; `prev`, `cnt` and the prescaler at 0.
- `rst` mid-press:
  - Any pending classification is dropped and no pulse is emitted.
  - The next cycle follows the reset values.
- `short_pulse` appears in the cycle after the first cycle in which `key_pressed[i]` is sampled 0.
- `long_pulse` appears in the cycle after the LONG_TICKS-th tick following `rise`.
  - The hold time from press therefore lies between (LONG_TICKS-1)·TICK_DIV+1 and LONG_TICKS·TICK_DIV cycles, because the prescaler phase is arbitrary.
- The first `repeat_pulse` comes exactly REPEAT_TICKS·TICK_DIV cycles after `long_pulse`, and each later one at the same spacing.

## Configuration
- `KEY_REPEAT_EN`:
  - Defined: LONG_HELD auto-repeat behaves as specified above.
  - Undefined: `repeat_pulse` is tied to 0. LONG_HELD only waits for `fall`, its counter logic is removed, and `REPEAT_TICKS` is ignored.

## Structure
- Package `key_event_pkg`:
  - FSM state typedef `key_state_t` (IDLE=2'd0, PRESSED=2'd1, LONG_HELD=2'd2).
  - Counter width constant `KEY_CNT_W = 16`.
  - Default tick constants.
- Sub-module `key_event_fsm`:
  - One instance per key, created with a generate loop.
  - Inputs: `clk`, `rst`, `tick`, and that key's level.
  - Owns its own `prev`, `cnt`, state and the three output bits.
- Top level: holds the prescaler and the generate loop.

## Test plan
Bench parameters: TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=3, WIDTH=4, `KEY_REPEAT_EN` defined.
- Key0 high for 8 cycles, then low → `short_pulse[0]`=1 for one cycle, one cycle after release; `long_pulse`=0 throughout.
- Key1 held for 60 cycles → `long_pulse[1]` between cycles 18 and 21 after the press, then `repeat_pulse[1]` at +12, +24 and +36 cycles; after release, no `short_pulse`.
- Key2 released in exactly the cycle of the 5th tick → only `short_pulse[2]`; no `long_pulse`.
- Keys 0 and 3 pressed and released together after 6 cycles → `short_pulse` = 4'b1001 in a single cycle.
- Key1 held for 15 cycles, `rst` pulsed for 1 cycle, then key released → no pulses at all. Key held into reset release → a new press is counted, and `long_pulse` follows about 20 cycles later.
- Build with `KEY_REPEAT_EN` undefined and hold key0 for 80 cycles → one `long_pulse[0]`; `repeat_pulse` stays 0.
